gpio_apb_sequencer12: RTL and testbench
=======================================

Name: gpio_apb_sequencer12

Overview:
APB Rev2 master that sits between the subsystem control logic and the gpio_lite12 slave port. It sequences register writes and reads into the GPIO on behalf of a single configuration requester. When gpio_int12 asserts, it reads the interrupt status register autonomously, and arbitrates between these two sources. Post-read holdoff prevents re-servicing before the GPIO drops its interrupt line.

Parameters:
ISR_ADDR, 6'h20, APB address of the GPIO interrupt status register (clear-on-read).
HOLDOFF, 2, idle cycles after an interrupt read before gpio_int12 is sampled again (1..15).
IRQ_CNT_W, 16, width of the interrupt service counter.

Ports:
pclk12  input  1  APB clock; all logic on the rising edge.
n_p_reset12  input  1  reset, synchronous, active-low.
cfg_req12  input  1  config transfer request; held with stable fields until cfg_ack12.
cfg_write12  input  1  1 = write, 0 = read.
cfg_addr12  input  6  target register address.
cfg_wdata12  input  16  write data.
cfg_ack12  output  1  one-cycle pulse: transfer complete.
cfg_rdata12  output  16  read data, valid while cfg_ack12 = 1, held until the next ack.
gpio_int12  input  1  interrupt from gpio_lite12.
irq_en12  input  1  enables autonomous interrupt service.
irq_valid12  output  1  one-cycle pulse: irq_status12 updated.
irq_status12  output  16  last interrupt status read.
irq_count12  output  IRQ_CNT_W  serviced-interrupt count (see Optional Feature).
psel12  output  1  APB select.
penable12  output  1  APB enable.
pwrite12  output  1  APB write.
paddr12  output  6  APB address.
pwdata12  output  32  APB write data; [31:16] always 0.
prdata12  input  32  APB read data; only [15:0] used.

Behaviour:
- Reset (n_p_reset12 low at a clock edge):
  - State goes to IDLE.
  - All outputs 0, HOLDOFF counter 0, round-robin pointer set to IRQ.
  - Reset mid-transfer aborts the transfer with no ack.
- States: IDLE, SETUP, ACCESS, HOLD.
- IDLE, candidates:
  - irq_pending = gpio_int12 & irq_en12.
  - cfg_pending = cfg_req12 & ~cfg_ack12.
- Arbitration:
  - With one candidate, grant it.
  - With both, grant per the round-robin pointer; the pointer flips to the other source after each grant.
- Grant latches the source, address, write flag and data, then IDLE -> SETUP.
  - IRQ grant: address ISR_ADDR, read.
  - CFG grant: cfg_addr12, cfg_write12, cfg_wdata12.
- SETUP (1 cycle): psel12=1, penable12=0, paddr12/pwrite12/pwdata12 driven. -> ACCESS.
- ACCESS (1 cycle): psel12=1, penable12=1, address/control stable. No wait states (no pready).
  - Reads capture prdata12[15:0] at the end of ACCESS.
  - psel12/penable12 return to 0 next cycle.
- After ACCESS:
  - CFG grant: cfg_ack12=1 for one cycle, cfg_rdata12 loaded on reads (unchanged on writes), -> IDLE.
  - IRQ grant: irq_valid12=1 for one cycle, irq_status12 loaded, -> HOLD.
- HOLD:
  - Counts HOLDOFF cycles with gpio_int12 ignored.
  - cfg requests may still be granted from HOLD directly to SETUP; the holdoff counter keeps running and gates irq only.
  - Returns to IDLE when the count expires.
- Latency: request seen in IDLE at cycle N gives SETUP at N+1, ACCESS at N+2, ack/valid at N+3. A new grant is possible at N+3; minimum 3 cycles per transfer.
- cfg_req12 is not re-granted in the cycle cfg_ack12 is high.
- Changing cfg fields while cfg_req12 is high before ack does not affect a latched transfer.
- psel12 is never high for more than 2 consecutive cycles per transfer; penable12 never rises without psel12.
- irq_en12 deasserted during an IRQ transfer: the transfer completes normally.

Optional Feature:
Macro GPIO_SEQ_IRQ_COUNT_EN.
- Defined: irq_count12 increments by 1 on each irq_valid12 pulse, saturates at all-ones, and clears on reset.
- Undefined: irq_count12 is constant 0 and no counter flops are built.

Test Plan:
- Reset, then cfg write addr 6'h04 data 16'hA5A5 -> SETUP at N+1, ACCESS at N+2 with pwdata12=32'h0000A5A5, pwrite12=1; cfg_ack12 at N+3.
- cfg read addr 6'h08, prdata12=32'hFFFF1234 -> cfg_rdata12=16'h1234 at ack; bits [31:16] ignored.
- irq_en12=1, gpio_int12=1, prdata12=16'h0081 on ISR_ADDR -> read of 6'h20, irq_valid12 with irq_status12=16'h0081; gpio_int12 held high, next IRQ SETUP not before HOLDOFF(2) cycles after valid.
- cfg_req12 and gpio_int12 both asserted continuously -> grants alternate IRQ, CFG, IRQ, CFG (IRQ first after reset).
- Reset asserted in ACCESS of a cfg write -> next cycle psel12=penable12=0 and no cfg_ack12; with macro, irq_count12=0.
- With GPIO_SEQ_IRQ_COUNT_EN, IRQ_CNT_W=2, 5 interrupts serviced -> irq_count12 = 1, 2, 3, 3, 3; without the macro it stays 0.

Source files
------------

// File: rtl/gpio_apb_sequencer12.sv
// gpio_apb_sequencer12
//
// APB master in front of the gpio_lite12 slave port. It serves two sources:
//   - a configuration requester (cfg_*), which gets single register reads or writes
//   - the GPIO interrupt line, which triggers an autonomous read of the
//     clear-on-read interrupt status register
// Round-robin arbitration decides between the two sources. After each
// interrupt read, a holdoff window masks gpio_int12 until the GPIO has had time
// to drop the line.
//
// Optional build macro: GPIO_SEQ_IRQ_COUNT_EN adds a saturating count of serviced
// interrupts on irq_count12. Without it, irq_count12 is tied to 0.
//
// Ports:
//   pclk12        in   APB clock, rising edge
//   n_p_reset12   in   synchronous active-low reset
//   cfg_req12     in   config request, fields stable until cfg_ack12
//   cfg_write12   in   1 = write, 0 = read
//   cfg_addr12    in   [5:0] register address
//   cfg_wdata12   in   [15:0] write data
//   cfg_ack12     out  one-cycle completion pulse
//   cfg_rdata12   out  [15:0] read data, held until next ack
//   gpio_int12    in   interrupt from gpio_lite12
//   irq_en12      in   enables autonomous interrupt service
//   irq_valid12   out  one-cycle pulse, irq_status12 updated
//   irq_status12  out  [15:0] last interrupt status read
//   irq_count12   out  [IRQ_CNT_W-1:0] serviced interrupt count
//   psel12, penable12, pwrite12, paddr12[5:0], pwdata12[31:0]  out  APB request
//   prdata12      in   [31:0] APB read data, low half used

module gpio_apb_sequencer12 #(
  parameter logic [5:0]  ISR_ADDR  = 6'h20,
  parameter int unsigned HOLDOFF   = 2,
  parameter int unsigned IRQ_CNT_W = 16
) (
  input  logic                 pclk12,
  input  logic                 n_p_reset12,
  input  logic                 cfg_req12,
  input  logic                 cfg_write12,
  input  logic [5:0]           cfg_addr12,
  input  logic [15:0]          cfg_wdata12,
  output logic                 cfg_ack12,
  output logic [15:0]          cfg_rdata12,
  input  logic                 gpio_int12,
  input  logic                 irq_en12,
  output logic                 irq_valid12,
  output logic [15:0]          irq_status12,
  output logic [IRQ_CNT_W-1:0] irq_count12,
  output logic                 psel12,
  output logic                 penable12,
  output logic                 pwrite12,
  output logic [5:0]           paddr12,
  output logic [31:0]          pwdata12,
  input  logic [31:0]          prdata12
);

  localparam logic [3:0] HoldLoad = 4'(HOLDOFF);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

  state_e      state_q, state_d;
  logic        src_irq_q, src_irq_d;   // source of the transfer in flight
  logic        rr_irq_q, rr_irq_d;     // 1: IRQ wins the next tie
  logic [5:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        ack_q, ack_d;
  logic        valid_q, valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] status_q, status_d;

  logic irq_pending, cfg_pending;
  logic grant_irq, grant_cfg;

  // Only the low half of prdata12 carries GPIO register data.
  logic unused_prdata_hi;
  assign unused_prdata_hi = ^prdata12[31:16];

  // The holdoff counter masks the interrupt line in every state, so a cfg
  // transfer granted out of HOLD cannot open an early window for the IRQ.
  assign irq_pending = gpio_int12 & irq_en12 & (hold_cnt_q == 4'd0);
  // The requester still holds cfg_req12 during its ack cycle. Mask it so the
  // same request is not granted twice.
  assign cfg_pending = cfg_req12 & ~ack_q;

  always_comb begin
    state_d    = state_q;
    src_irq_d  = src_irq_q;
    rr_irq_d   = rr_irq_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    ack_d      = 1'b0;
    valid_d    = 1'b0;
    hold_cnt_d = (hold_cnt_q != 4'd0) ? hold_cnt_q - 4'd1 : 4'd0;
    grant_irq  = 1'b0;
    grant_cfg  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (irq_pending && cfg_pending) begin
          grant_irq = rr_irq_q;
          grant_cfg = ~rr_irq_q;
        end else begin
          grant_irq = irq_pending;
          grant_cfg = cfg_pending;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (src_irq_q) begin
          valid_d    = 1'b1;
          status_d   = prdata12[15:0];
          hold_cnt_d = HoldLoad;
          state_d    = StHold;
        end else begin
          ack_d = 1'b1;
          if (!write_q) rdata_d = prdata12[15:0];
          state_d = StIdle;
        end
      end
      StHold: begin
        // IRQ is masked here, so only the requester competes.
        grant_cfg = cfg_pending;
        if (hold_cnt_q <= 4'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (grant_irq) begin
      state_d   = StSetup;
      src_irq_d = 1'b1;
      rr_irq_d  = 1'b0;
      addr_d    = ISR_ADDR;
      write_d   = 1'b0;
      wdata_d   = 16'h0000;
    end else if (grant_cfg) begin
      state_d   = StSetup;
      src_irq_d = 1'b0;
      rr_irq_d  = 1'b1;
      addr_d    = cfg_addr12;
      write_d   = cfg_write12;
      wdata_d   = cfg_wdata12;
    end
  end

  always_ff @(posedge pclk12) begin
    if (!n_p_reset12) begin
      state_q    <= StIdle;
      src_irq_q  <= 1'b0;
      rr_irq_q   <= 1'b1;
      addr_q     <= 6'h00;
      write_q    <= 1'b0;
      wdata_q    <= 16'h0000;
      hold_cnt_q <= 4'd0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= 16'h0000;
      status_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      src_irq_q  <= src_irq_d;
      rr_irq_q   <= rr_irq_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      hold_cnt_q <= hold_cnt_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
    end
  end

`ifdef GPIO_SEQ_IRQ_COUNT_EN
  logic [IRQ_CNT_W-1:0] irq_count_q;

  // Count on the edge that raises irq_valid12, so the new count is visible
  // together with the pulse.
  always_ff @(posedge pclk12) begin
    if (!n_p_reset12) begin
      irq_count_q <= '0;
    end else if (valid_d && !(&irq_count_q)) begin
      irq_count_q <= irq_count_q + {{(IRQ_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign irq_count12 = irq_count_q;
`else
  assign irq_count12 = '0;
`endif

  assign psel12       = (state_q == StSetup) || (state_q == StAccess);
  assign penable12    = (state_q == StAccess);
  assign pwrite12     = write_q;
  assign paddr12      = addr_q;
  assign pwdata12     = {16'h0000, wdata_q};
  assign cfg_ack12    = ack_q;
  assign cfg_rdata12  = rdata_q;
  assign irq_valid12  = valid_q;
  assign irq_status12 = status_q;

endmodule

// File: tb/tb_gpio_apb_sequencer12.sv
// Randomised bench for gpio_apb_sequencer12. The reference model works per
// transfer. Each grant is one record with a grant time. The bus phases, the
// completion pulse and the holdoff window are all derived from that grant time
// with plain arithmetic.
module tb_gpio_apb_sequencer12;
  localparam int unsigned HOLDOFF = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [5:0]  ISR     = 6'h20;

  logic             pclk12 = 1'b0;
  logic             n_p_reset12;
  logic             cfg_req12, cfg_write12;
  logic [5:0]       cfg_addr12;
  logic [15:0]      cfg_wdata12;
  logic             cfg_ack12;
  logic [15:0]      cfg_rdata12;
  logic             gpio_int12, irq_en12, irq_valid12;
  logic [15:0]      irq_status12;
  logic [CNT_W-1:0] irq_count12;
  logic             psel12, penable12, pwrite12;
  logic [5:0]       paddr12;
  logic [31:0]      pwdata12, prdata12;

  always #5 pclk12 = ~pclk12;

  gpio_apb_sequencer12 #(
    .ISR_ADDR (ISR),
    .HOLDOFF  (HOLDOFF),
    .IRQ_CNT_W(CNT_W)
  ) dut (
    .pclk12      (pclk12),
    .n_p_reset12 (n_p_reset12),
    .cfg_req12   (cfg_req12),
    .cfg_write12 (cfg_write12),
    .cfg_addr12  (cfg_addr12),
    .cfg_wdata12 (cfg_wdata12),
    .cfg_ack12   (cfg_ack12),
    .cfg_rdata12 (cfg_rdata12),
    .gpio_int12  (gpio_int12),
    .irq_en12    (irq_en12),
    .irq_valid12 (irq_valid12),
    .irq_status12(irq_status12),
    .irq_count12 (irq_count12),
    .psel12      (psel12),
    .penable12   (penable12),
    .pwrite12    (pwrite12),
    .paddr12     (paddr12),
    .pwdata12    (pwdata12),
    .prdata12    (prdata12)
  );

  int total = 0;
  int bad   = 0;
  int t     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Reference model state: one in-flight transfer record plus time stamps.
  int          free_at, irq_ok_at, fl_g, n_irq;
  bit          fl_valid, fl_irq, fl_write, last_irq, just_reset, rst_pend;
  logic [5:0]  fl_addr;
  logic [15:0] fl_wdata, fl_rd, exp_rdata, exp_status;

  // Requester behaviour. req_state is 0 when idle, 1 when pending, and 2 when
  // granted (fields are then free to change).
  typedef struct packed {logic w; logic [5:0] a; logic [15:0] d;} cfg_t;
  cfg_t        cfg_q[$];
  int          req_state, p_req, int_mode, p_int, p_rst;
  bit          rnd_en, rnd_prdata, arm_rst;
  logic [31:0] fix_prdata;

  task automatic new_request();
    cfg_t c;
    if (cfg_q.size() > 0) c = cfg_q.pop_front();
    else begin
      c.w = 1'($urandom_range(1));
      c.a = 6'($urandom);
      c.d = 16'($urandom);
    end
    cfg_req12   = 1'b1;
    cfg_write12 = c.w;
    cfg_addr12  = c.a;
    cfg_wdata12 = c.d;
    req_state   = 1;
  endtask

  task automatic model_reset();
    free_at    = t;
    irq_ok_at  = t;
    fl_valid   = 0;
    last_irq   = 0;      // IRQ wins the first tie
    exp_rdata  = 16'h0;
    exp_status = 16'h0;
    n_irq      = 0;
    just_reset = 1;
    if (req_state == 2) req_state = 1;
  endtask

  task automatic step();
    bit e_psel, e_pen, e_ack, e_valid, do_rst, c_irq, c_cfg, pick_irq;
    int e_cnt;
    @(posedge pclk12);
    #1;
    if (rst_pend) begin
      model_reset();
      rst_pend = 0;
    end
    e_psel  = fl_valid && (t == fl_g + 1 || t == fl_g + 2);
    e_pen   = fl_valid && (t == fl_g + 2);
    e_ack   = fl_valid && !fl_irq && (t == fl_g + 3);
    e_valid = fl_valid && fl_irq && (t == fl_g + 3);
    if (e_ack && !fl_write) exp_rdata = fl_rd;
    if (e_valid) begin
      exp_status = fl_rd;
      n_irq++;
    end
    if (fl_valid && t == fl_g + 3) fl_valid = 0;
`ifdef GPIO_SEQ_IRQ_COUNT_EN
    e_cnt = (n_irq > CNT_MAX) ? CNT_MAX : n_irq;
`else
    e_cnt = 0;
`endif

    check_eq("psel", 32'(psel12), 32'(e_psel));
    check_eq("penable", 32'(penable12), 32'(e_pen));
    check_eq("penable_wo_psel", 32'(penable12 & ~psel12), 32'd0);
    check_eq("cfg_ack", 32'(cfg_ack12), 32'(e_ack));
    check_eq("irq_valid", 32'(irq_valid12), 32'(e_valid));
    check_eq("cfg_rdata", 32'(cfg_rdata12), 32'(exp_rdata));
    check_eq("irq_status", 32'(irq_status12), 32'(exp_status));
    check_eq("irq_count", 32'(irq_count12), 32'(e_cnt));
    if (just_reset) begin
      check_eq("rst_paddr", 32'(paddr12), 32'd0);
      check_eq("rst_pwrite", 32'(pwrite12), 32'd0);
      check_eq("rst_pwdata", pwdata12, 32'd0);
    end else if (e_psel) begin
      check_eq("paddr", 32'(paddr12), 32'(fl_addr));
      check_eq("pwrite", 32'(pwrite12), 32'(fl_write));
      check_eq("pwdata", pwdata12, {16'h0000, fl_wdata});
    end
    just_reset = 0;

    if (e_ack) begin
      if (p_req > 0 && (cfg_q.size() > 0 || $urandom_range(1) == 1)) new_request();
      else begin
        cfg_req12 = 1'b0;
        req_state = 0;
      end
    end

    do_rst = 0;
    if (arm_rst && fl_valid && !fl_irq && fl_write && t == fl_g + 2) begin
      do_rst  = 1;
      arm_rst = 0;
    end
    if (p_rst > 0 && $urandom_range(999) < p_rst) do_rst = 1;
    n_p_reset12 = !do_rst;

    if (req_state == 0 && p_req > 0 && $urandom_range(99) < p_req) new_request();
    else if (req_state == 2) begin
      cfg_write12 = 1'($urandom);
      cfg_addr12  = 6'($urandom);
      cfg_wdata12 = 16'($urandom);
    end
    case (int_mode)
      0:       gpio_int12 = 1'b0;
      1:       gpio_int12 = 1'b1;
      default: gpio_int12 = ($urandom_range(99) < p_int);
    endcase
    irq_en12 = rnd_en ? ($urandom_range(9) != 0) : 1'b1;
    prdata12 = rnd_prdata ? $urandom : fix_prdata;
    if (fl_valid && t == fl_g + 2) fl_rd = prdata12[15:0];

    if (do_rst) rst_pend = 1;
    else if (t >= free_at) begin
      c_irq = gpio_int12 && irq_en12 && (t >= irq_ok_at);
      c_cfg = cfg_req12 && !e_ack;
      if (c_irq || c_cfg) begin
        pick_irq = (c_irq && c_cfg) ? !last_irq : c_irq;
        fl_valid = 1;
        fl_g     = t;
        fl_irq   = pick_irq;
        last_irq = pick_irq;
        free_at  = t + 3;
        if (pick_irq) begin
          fl_addr   = ISR;
          fl_write  = 0;
          fl_wdata  = 16'h0;
          irq_ok_at = t + 3 + int'(HOLDOFF);
        end else begin
          fl_addr   = cfg_addr12;
          fl_write  = cfg_write12;
          fl_wdata  = cfg_wdata12;
          req_state = 2;
        end
      end
    end
    t++;
  endtask

  initial begin
    n_p_reset12 = 1'b0;
    cfg_req12   = 1'b0;
    cfg_write12 = 1'b0;
    cfg_addr12  = 6'h0;
    cfg_wdata12 = 16'h0;
    gpio_int12  = 1'b0;
    irq_en12    = 1'b0;
    prdata12    = 32'h0;
    req_state   = 0;
    p_req       = 0;
    int_mode    = 0;
    p_int       = 0;
    p_rst       = 0;
    rnd_en      = 0;
    rnd_prdata  = 0;
    arm_rst     = 0;
    fix_prdata  = 32'h0;
    fl_valid    = 0;
    repeat (3) @(posedge pclk12);
    rst_pend = 1;

    // Directed cfg write, then a read whose upper prdata half must be ignored.
    cfg_q.push_back('{w: 1'b1, a: 6'h04, d: 16'hA5A5});
    cfg_q.push_back('{w: 1'b0, a: 6'h08, d: 16'h0000});
    p_req      = 100;
    fix_prdata = 32'hFFFF_1234;
    repeat (12) step();

    // Drain the requester. Then hold the interrupt high for repeated service
    // across the holdoff window.
    p_req = 0;
    repeat (8) step();
    int_mode   = 1;
    fix_prdata = 32'h0000_0081;
    repeat (20) step();

    // Both sources busy: grants must alternate.
    p_req = 100;
    repeat (30) step();

    // Reset in the ACCESS phase of a cfg write.
    p_req    = 0;
    int_mode = 0;
    repeat (8) step();
    cfg_q.push_back('{w: 1'b1, a: 6'h10, d: 16'h5A5A});
    arm_rst = 1;
    p_req   = 100;
    repeat (15) step();

    // Random traffic with occasional resets.
    p_req      = 30;
    int_mode   = 2;
    p_int      = 40;
    rnd_en     = 1;
    rnd_prdata = 1;
    p_rst      = 3;
    repeat (3000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
